// File: rtl/uart_reg_frame_rx.sv
// uart_reg_frame_rx: parses framed register-write commands out of the UART
// byte stream. Frame: SYNC, address, sub-address, data_hi, data_lo, and
// optionally an XOR checksum. One reg_valid strobe is issued per good frame.
// A stall between bytes (timeout) or a bad checksum raises frame_err and
// bumps a saturating error counter.
// Build option: define UART_REG_CHECKSUM_EN for 6-byte frames with checksum.
module uart_reg_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        reg_valid,
    output logic [7:0]  reg_address,
    output logic [7:0]  reg_sub_address,
    output logic [15:0] reg_data,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int               GAP_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_REG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SUB, S_DHI, S_DLO, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SUB, S_DHI, S_DLO} state_t;
`endif

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       sub_q, sub_d;
    logic [7:0]       dhi_q, dhi_d;
    logic [7:0]       commit_lo;
    logic             commit;
    logic             err;
`ifdef UART_REG_CHECKSUM_EN
    logic [7:0]       dlo_q, dlo_d;
`endif

    logic             reg_valid_q;
    logic [7:0]       reg_address_q;
    logic [7:0]       reg_sub_address_q;
    logic [15:0]      reg_data_q;
    logic             frame_err_q;
    logic [7:0]       err_cnt_q;

    // Next-state, shadow capture, gap counting and commit/error decisions.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        sub_d     = sub_q;
        dhi_d     = dhi_q;
        commit    = 1'b0;
        commit_lo = rx_data;
        err       = 1'b0;
`ifdef UART_REG_CHECKSUM_EN
        dlo_d     = dlo_q;
        commit_lo = dlo_q;
`endif
        if (state_q != S_IDLE) begin
            gap_d = gap_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (rx_valid) begin
                    sub_d   = rx_data;
                    state_d = S_DHI;
                end
            end
            S_DHI: begin
                if (rx_valid) begin
                    dhi_d   = rx_data;
                    state_d = S_DLO;
                end
            end
            S_DLO: begin
                if (rx_valid) begin
`ifdef UART_REG_CHECKSUM_EN
                    dlo_d   = rx_data;
                    state_d = S_CSUM;
`else
                    commit  = 1'b1;
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef UART_REG_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == (addr_q ^ sub_q ^ dhi_q ^ dlo_q)) begin
                        commit = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A byte in the terminal-count cycle wins over the timeout.
        if (state_q != S_IDLE) begin
            if (rx_valid) begin
                gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
                err     = 1'b1;
                state_d = S_IDLE;
                gap_d   = '0;
            end
        end
        if (state_q == S_IDLE) begin
            gap_d = '0;
        end
    end

    // Control state, gap counter, output registers and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            gap_q             <= '0;
            reg_valid_q       <= 1'b0;
            reg_address_q     <= 8'h00;
            reg_sub_address_q <= 8'h00;
            reg_data_q        <= 16'h0000;
            frame_err_q       <= 1'b0;
            err_cnt_q         <= 8'h00;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            reg_valid_q <= commit;
            frame_err_q <= err;
            if (commit) begin
                reg_address_q     <= addr_q;
                reg_sub_address_q <= sub_q;
                reg_data_q        <= {dhi_q, commit_lo};
            end
            if (err && (err_cnt_q != 8'hff)) begin
                err_cnt_q <= err_cnt_q + 8'h01;
            end
        end
    end

    // Shadow fields of the frame in flight; only read once a frame completes.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        sub_q  <= sub_d;
        dhi_q  <= dhi_d;
`ifdef UART_REG_CHECKSUM_EN
        dlo_q  <= dlo_d;
`endif
    end

    assign reg_valid       = reg_valid_q;
    assign reg_address     = reg_address_q;
    assign reg_sub_address = reg_sub_address_q;
    assign reg_data        = reg_data_q;
    assign frame_err       = frame_err_q;
    assign err_cnt         = err_cnt_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_frame_rx.sv
// Directed bench for uart_reg_frame_rx (small TIMEOUT_CYCLES for short runs).
module tb_uart_reg_frame_rx;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reg_valid;
    logic [7:0]  reg_address;
    logic [7:0]  reg_sub_address;
    logic [15:0] reg_data;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int ecnt = 0;
    int v0;
    int e0;

    uart_reg_frame_rx #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .reg_valid      (reg_valid),
        .reg_address    (reg_address),
        .reg_sub_address(reg_sub_address),
        .reg_data       (reg_data),
        .frame_err      (frame_err),
        .err_cnt        (err_cnt),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_valid === 1'b1) vcnt++;
        if (frame_err === 1'b1) ecnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns 1 time unit after the sampling edge.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        chk("rst_reg_valid", 16'(reg_valid), 16'h0);
        chk("rst_address", 16'(reg_address), 16'h00);
        chk("rst_sub", 16'(reg_sub_address), 16'h00);
        chk("rst_data", reg_data, 16'h0000);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_err_cnt", 16'(err_cnt), 16'h00);
        chk("rst_busy", 16'(busy), 16'h0);
        rst_n = 1'b1;
        idle(2);

        // Good frame with 10-cycle gaps
        v0 = vcnt;
        put(8'h55);
        chk("good_busy", 16'(busy), 16'h1);
        idle(10); put(8'hff);
        idle(10); put(8'h03);
        idle(10); put(8'h0a);
        idle(10); put(8'hbc);
`ifdef UART_REG_CHECKSUM_EN
        chk("good_no_early_valid", 16'(reg_valid), 16'h0);
        idle(10); put(8'h4a);
`endif
        chk("good_valid", 16'(reg_valid), 16'h1);
        chk("good_address", 16'(reg_address), 16'h00ff);
        chk("good_sub", 16'(reg_sub_address), 16'h0003);
        chk("good_data", reg_data, 16'h0abc);
        chk("good_frame_err", 16'(frame_err), 16'h0);
        idle(1);
        chk("good_valid_one_cycle", 16'(reg_valid), 16'h0);
        chk("good_busy_low", 16'(busy), 16'h0);
        chk("good_err_cnt", 16'(err_cnt), 16'h00);
        chk("good_strobe_count", 16'(vcnt - v0), 16'h1);

`ifdef UART_REG_CHECKSUM_EN
        // Checksum mismatch: fe^00^12^34 = d8, 00 sent
        v0 = vcnt;
        put(8'h55); put(8'hfe); put(8'h00); put(8'h12); put(8'h34); put(8'h00);
        chk("csum_frame_err", 16'(frame_err), 16'h1);
        chk("csum_no_valid", 16'(reg_valid), 16'h0);
        chk("csum_err_cnt", 16'(err_cnt), 16'h01);
        chk("csum_hold_address", 16'(reg_address), 16'h00ff);
        chk("csum_hold_data", reg_data, 16'h0abc);
        idle(1);
        chk("csum_err_one_cycle", 16'(frame_err), 16'h0);
        chk("csum_strobe_count", 16'(vcnt - v0), 16'h0);
`endif

        // Timeout after 55 ff 01
        e0 = ecnt;
        put(8'h55); put(8'hff); put(8'h01);
        idle(TO - 1);
        chk("to_not_yet", 16'(frame_err), 16'h0);
        chk("to_busy_before", 16'(busy), 16'h1);
        idle(1);
        chk("to_frame_err", 16'(frame_err), 16'h1);
        chk("to_busy_low", 16'(busy), 16'h0);
`ifdef UART_REG_CHECKSUM_EN
        chk("to_err_cnt", 16'(err_cnt), 16'h02);
`else
        chk("to_err_cnt", 16'(err_cnt), 16'h01);
`endif
        idle(1);
        chk("to_err_pulse_count", 16'(ecnt - e0), 16'h1);
        put(8'h55); put(8'h12); put(8'h34); put(8'h56); put(8'h78);
`ifdef UART_REG_CHECKSUM_EN
        put(8'h08);
`endif
        chk("after_to_valid", 16'(reg_valid), 16'h1);
        chk("after_to_address", 16'(reg_address), 16'h0012);
        chk("after_to_data", reg_data, 16'h5678);

        // Leading garbage, then a frame, then a back-to-back frame containing 55 as data
        idle(2);
        v0 = vcnt;
        e0 = ecnt;
        put(8'h00); put(8'haa); put(8'h13);
        chk("garbage_busy", 16'(busy), 16'h0);
        put(8'h55); put(8'h00); put(8'h00); put(8'h00); put(8'h01);
`ifdef UART_REG_CHECKSUM_EN
        put(8'h01);
`endif
        chk("garbage_valid", 16'(reg_valid), 16'h1);
        chk("garbage_address", 16'(reg_address), 16'h0000);
        chk("garbage_sub", 16'(reg_sub_address), 16'h0000);
        chk("garbage_data", reg_data, 16'h0001);
        put(8'h55); put(8'ha5); put(8'h5a); put(8'h55); put(8'hc3);
`ifdef UART_REG_CHECKSUM_EN
        put(8'h69);
`endif
        chk("b2b_valid", 16'(reg_valid), 16'h1);
        chk("b2b_address", 16'(reg_address), 16'h00a5);
        chk("b2b_sub", 16'(reg_sub_address), 16'h005a);
        chk("b2b_data", reg_data, 16'h55c3);
        idle(1);
        chk("garbage_strobe_count", 16'(vcnt - v0), 16'h2);
        chk("garbage_no_err", 16'(ecnt - e0), 16'h0);

        // Asynchronous reset mid-frame
        put(8'h55); put(8'hff); put(8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 16'(busy), 16'h0);
        chk("mrst_address", 16'(reg_address), 16'h00);
        chk("mrst_sub", 16'(reg_sub_address), 16'h00);
        chk("mrst_data", reg_data, 16'h0000);
        chk("mrst_err_cnt", 16'(err_cnt), 16'h00);
        chk("mrst_valid", 16'(reg_valid), 16'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        v0 = vcnt;
        put(8'h11); put(8'h22);
        idle(3);
        chk("mrst_tail_busy", 16'(busy), 16'h0);
        chk("mrst_tail_no_strobe", 16'(vcnt - v0), 16'h0);

        // Every byte lands exactly on the timeout terminal count
        v0 = vcnt;
        put(8'h55);
        idle(TO - 1); put(8'h01);
        chk("tc_accept_no_err", 16'(frame_err), 16'h0);
        chk("tc_accept_busy", 16'(busy), 16'h1);
        idle(TO - 1); put(8'h02);
        idle(TO - 1); put(8'h03);
        idle(TO - 1); put(8'h04);
`ifdef UART_REG_CHECKSUM_EN
        idle(TO - 1); put(8'h04);
`endif
        chk("tc_valid", 16'(reg_valid), 16'h1);
        chk("tc_address", 16'(reg_address), 16'h0001);
        chk("tc_sub", 16'(reg_sub_address), 16'h0002);
        chk("tc_data", reg_data, 16'h0304);
        chk("tc_err_cnt", 16'(err_cnt), 16'h00);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
`ifdef UART_REG_CHECKSUM_EN
            put(8'h55); put(8'h00); put(8'h00); put(8'h00); put(8'h00); put(8'hff);
`else
            put(8'h55); idle(TO);
`endif
            if (i == 9) chk("sat_mid_cnt", 16'(err_cnt), 16'h0a);
        end
        chk("sat_last_err", 16'(frame_err), 16'h1);
        chk("sat_err_cnt", 16'(err_cnt), 16'h00ff);
        chk("sat_keep_data", reg_data, 16'h0304);
        idle(2);
        chk("sat_err_cnt_hold", 16'(err_cnt), 16'h00ff);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_reg_frame_rx.md
# uart_reg_frame_rx

Receive-side command-frame parser between the UART byte receiver and the register file of the top level. Consumes received bytes, locates framed register-write commands (sync, address, sub-address, 16-bit data, optional checksum) and issues one single-cycle register-write strobe per valid frame. Rejects malformed or stalled frames with an error pulse and a saturating error counter, so the DAC and ADC-frequency registers never take a partial write.

## Interface
Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CYCLES, 25000, maximum clk cycles allowed between consecutive bytes of one frame (1 ms at 25 MHz SYS_CLK); minimum 2.

Ports:
- clk  in  1  system clock (SYS_CLK domain), all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid only while rx_valid is high.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- reg_valid  out  1  single-cycle write strobe for a good frame.
- reg_address  out  8  frame address field (8'hff DAC, 8'hfe ADC freq, 8'h00 enable).
- reg_sub_address  out  8  frame sub-address field.
- reg_data  out  16  frame data, {data_hi, data_lo}.
- frame_err  out  1  single-cycle pulse on checksum mismatch or timeout.
- err_cnt  out  8  saturating count of frame_err pulses.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ADDR, SUB, DHI, DLO, CSUM (CSUM only with checksum enabled).
- IDLE: rx_valid with rx_data == SYNC_BYTE -> ADDR; any other byte discarded, no error.
- ADDR/SUB/DHI/DLO: each rx_valid captures rx_data into a shadow register and advances one state. SYNC_BYTE inside a frame is ordinary data; no escaping, no resync.
- After DLO byte: with checksum -> CSUM; without -> commit, return to IDLE.
- CSUM: received byte compared against XOR of address, sub, data_hi, data_lo. Match -> commit; mismatch -> frame_err, no commit. Either way -> IDLE.
- Commit: shadow registers copied to reg_address/reg_sub_address/reg_data, reg_valid pulsed. Outputs hold last committed values until next commit.
- Timeout: gap counter cleared on entry to ADDR and on every accepted byte; increments each cycle outside IDLE. Counter reaching TIMEOUT_CYCLES-1 without rx_valid -> frame_err, IDLE, shadow discarded.
- Simultaneous rx_valid and timeout terminal count: byte wins, counter clears, no error.
- err_cnt increments on each frame_err, saturates at 8'hff, cleared only by reset.
- rst_n low mid-frame: immediate return to IDLE, partial frame lost, no strobe.

## Timing
- Reset values: reg_valid 0, reg_address 8'h00, reg_sub_address 8'h00, reg_data 16'h0000, frame_err 0, err_cnt 0, busy 0, state IDLE, gap counter 0.
- reg_valid asserted in the cycle after the clk edge sampling the final byte's rx_valid; high for exactly one cycle. Output fields valid in the same cycle and after.
- frame_err: one cycle, the cycle after the offending byte or after the timeout terminal count.
- busy goes high the cycle after sync is accepted; low the cycle after commit/error.
- Back-to-back frames: a sync byte arriving the cycle right after the final byte is accepted; no dead cycles.
- Gap counter width: $clog2(TIMEOUT_CYCLES).

## Configuration
- UART_REG_CHECKSUM_EN defined: 6-byte frames (sync, addr, sub, hi, lo, xor); CSUM state present; mismatch produces frame_err.
- Undefined: 5-byte frames, CSUM state absent, commit after data_lo; frame_err arises only from timeout.

## Test plan
- Good frame 55 ff 03 0a bc [+ checksum 4a] with 10-cycle gaps -> one reg_valid, address ff, sub 03, data 0abc; frame_err 0, err_cnt 0.
- With UART_REG_CHECKSUM_EN: 55 fe 00 12 34 00 -> frame_err one cycle, err_cnt 1, no reg_valid, outputs keep previous values.
- 55 ff 01 then TIMEOUT_CYCLES idle cycles -> frame_err, busy low; a following complete frame commits normally.
- Leading garbage 00 aa 13 then 55 00 00 00 01 [+ 01] -> exactly one reg_valid, address 00, data 0001, no frame_err.
- rst_n pulsed low after 55 ff 02 -> all outputs at reset values, busy 0; remaining bytes 11 22 ignored, no strobe.
- 300 consecutive bad-checksum frames -> err_cnt saturates at ff; byte landing exactly on timeout terminal count is accepted without error.
